// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The datapath is the master: it drives hazard inputs and consumes stage enables.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             idex_memread;
    logic [4:0]       idex_ard;
    logic [4:0]       ifid_ars1;
    logic [4:0]       ifid_ars2;
    logic             ifid_uses_rs2;
    logic             branch_taken;
    logic             mem_busy;
    logic             cnt_clr;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_err;

    modport master (
        output idex_memread, idex_ard, ifid_ars1, ifid_ars2, ifid_uses_rs2,
               branch_taken, mem_busy, cnt_clr,
        input  pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
               idex_bubble, state, stall_cnt, mem_err
    );

    modport slave (
        input  idex_memread, idex_ard, ifid_ars1, ifid_ars2, ifid_uses_rs2,
               branch_taken, mem_busy, cnt_clr,
        output pc_write, ifid_write, idex_write, exmem_write, ifid_flush,
               idex_bubble, state, stall_cnt, mem_err
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, branch flush, memory wait
// with a stall-cycle counter and a sticky memory-timeout flag.
module pipe_hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_hazard_ctrl_if.slave   hz
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_e;

    localparam int                WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               mem_err_q, mem_err_d;

    logic lu;
    logic pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_bubble;

    assign lu = hz.idex_memread && (hz.idex_ard != 5'd0) &&
                ((hz.idex_ard == hz.ifid_ars1) ||
                 (hz.ifid_uses_rs2 && (hz.idex_ard == hz.ifid_ars2)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // LOAD_STALL and MEM_WAIT fall through to the RUN rules once memory is free.
    always_comb begin
        state_d = RUN;
        if (hz.mem_busy)            state_d = MEM_WAIT;
        else if (hz.branch_taken)   state_d = FLUSH;
        else if (state_q == FLUSH)  state_d = RUN;
        else if (lu)                state_d = LOAD_STALL;
    end

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (!rst_n) begin
            // everything held off while in reset
        end else if (hz.mem_busy) begin
            // whole pipe frozen
        end else if (hz.branch_taken) begin
            {pc_write, ifid_write, idex_write, exmem_write} = 4'b1111;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state_q == FLUSH) begin
            // second flush squashes the word the synchronous imem already fetched
            {pc_write, ifid_write, idex_write, exmem_write} = 4'b1111;
            ifid_flush  = 1'b1;
        end else if (lu) begin
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            {pc_write, ifid_write, idex_write, exmem_write} = 4'b1111;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz.cnt_clr)                               stall_cnt_d = '0;
        else if (!pc_write && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + 1'b1;

        wait_cnt_d = '0;
        if (hz.mem_busy) begin
            wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end

        mem_err_d = mem_err_q | (hz.mem_busy && (wait_cnt_q >= WAIT_MAX - 1'b1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.idex_write  = idex_write;
    assign hz.exmem_write = exmem_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.state       = state_q;
    assign hz.stall_cnt   = stall_cnt_q;
    assign hz.mem_err     = mem_err_q;
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of STALL_CNT.
REQ-002 Parameter: TIMEOUT, 255, consecutive MEM_BUSY cycles before MEM_ERR (>=1).
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 IDEX_MEMREAD  in  1  load currently in EX (ID/EX output).
REQ-006 IDEX_ARD  in  5  destination register of instruction in EX.
REQ-007 IFID_ARS1, IFID_ARS2  in  5 each  source registers of instruction in ID.
REQ-008 IFID_USES_RS2  in  1  instruction in ID reads rs2.
REQ-009 BRANCH_TAKEN  in  1  taken branch/jump resolved in EX this cycle.
REQ-010 MEM_BUSY  in  1  data memory not ready; MEM stage must hold.
REQ-011 CNT_CLR  in  1  synchronous clear of STALL_CNT.
REQ-012 PC_WRITE, IFID_WRITE, IDEX_WRITE, EXMEM_WRITE  out  1 each  stage register enables.
REQ-013 IFID_FLUSH  out  1  load NOP into IF/ID; IDEX_BUBBLE  out  1  force all ID/EX control fields to 0.
REQ-014 STATE  out  2  RUN=0, LOAD_STALL=1, FLUSH=2, MEM_WAIT=3.
REQ-015 STALL_CNT  out  CNT_W  saturating count of cycles with PC_WRITE=0; MEM_ERR  out  1  sticky memory timeout.

Function
REQ-016 Load-use (LU) SHALL be true when IDEX_MEMREAD=1, IDEX_ARD!=0, and IDEX_ARD==IFID_ARS1 or (IFID_USES_RS2=1 and IDEX_ARD==IFID_ARS2).
REQ-017 Control outputs SHALL be combinational from STATE and inputs, evaluated by priority P1..P5 below; first match wins.
REQ-018 P1 MEM_BUSY=1: all four *_WRITE=0, IFID_FLUSH=0, IDEX_BUBBLE=0; next STATE=MEM_WAIT; BRANCH_TAKEN/LU ignored.
REQ-019 P2 BRANCH_TAKEN=1: all *_WRITE=1, IFID_FLUSH=1, IDEX_BUBBLE=1; next STATE=FLUSH.
REQ-020 P3 STATE=FLUSH: all *_WRITE=1, IFID_FLUSH=1 (squashes stale synchronous-imem word), IDEX_BUBBLE=0, LU not evaluated; next STATE=RUN.
REQ-021 P4 LU=1: PC_WRITE=0, IFID_WRITE=0, IDEX_WRITE=1, EXMEM_WRITE=1, IDEX_BUBBLE=1, IFID_FLUSH=0; next STATE=LOAD_STALL.
REQ-022 P5 otherwise: all *_WRITE=1, IFID_FLUSH=0, IDEX_BUBBLE=0; next STATE=RUN.
REQ-023 STATE=MEM_WAIT and LOAD_STALL with MEM_BUSY=0 SHALL be evaluated exactly as RUN (P2, P4, P5).
REQ-024 STALL_CNT SHALL increment at each edge where PC_WRITE=0, saturating at all-ones; CNT_CLR=1 clears to 0 with priority over increment.
REQ-025 Internal WAIT_CNT (width clog2(TIMEOUT+1)) SHALL increment at each edge with MEM_BUSY=1 and clear at each edge with MEM_BUSY=0; saturates at TIMEOUT.
REQ-026 MEM_ERR SHALL set at the edge completing TIMEOUT consecutive MEM_BUSY=1 cycles and remain 1 until reset.

Reset
REQ-027 rst=0 SHALL immediately force STATE=RUN, STALL_CNT=0, WAIT_CNT=0, MEM_ERR=0, independent of clk.
REQ-028 While rst=0, all *_WRITE, IFID_FLUSH, IDEX_BUBBLE SHALL be 0.
REQ-029 After rst rises, the first edge SHALL behave as RUN per P1..P5.

Verification
REQ-030 IDEX_MEMREAD=1, IDEX_ARD=5, IFID_ARS1=5 -> same cycle PC_WRITE=0, IFID_WRITE=0, IDEX_BUBBLE=1; next cycle STATE=1, STALL_CNT=1.
REQ-031 IDEX_MEMREAD=1, IDEX_ARD=0, IFID_ARS1=0; and ARD=7, ARS2=7, USES_RS2=0 -> no stall, all *_WRITE=1.
REQ-032 BRANCH_TAKEN=1 one cycle -> IFID_FLUSH=1 two consecutive cycles, IDEX_BUBBLE=1 first cycle only, STATE 2 then 0, STALL_CNT unchanged.
REQ-033 MEM_BUSY=1 three cycles with BRANCH_TAKEN=1 held -> all *_WRITE=0 for 3 cycles, STALL_CNT=3, IFID_FLUSH=1 on cycle MEM_BUSY falls.
REQ-034 TIMEOUT=4, MEM_BUSY=1 ten cycles -> MEM_ERR=1 after 4th edge, stays 1 after MEM_BUSY=0; CNT_W=2 saturates STALL_CNT at 3.
REQ-035 rst=0 asserted mid-MEM_WAIT between edges -> STATE=0, STALL_CNT=0, MEM_ERR=0 immediately; outputs 0 until rst=1.
